// File: rtl/ecc_pkg.sv
// Shared ECC datapath definitions: inverter state encoding and the P-192 prime.
// Imported by the inverter RTL, and by point-arithmetic controllers and benches.
package ecc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    DONE = 2'd2
  } inv_state_e;

  localparam logic [191:0] P192 = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff;

endpackage

// File: rtl/modular_inverter_if.sv
// Start/flag handshake bundle between the inverter and its controller.
// The controller drives operand and modulus; the inverter returns result and status.
interface modular_inverter_if #(parameter int N = 192);

  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] p;
  logic [N-1:0] Inv;
  logic         flag;
  logic         busy;
  logic         err;

  modport master (output start, A, p, input Inv, flag, busy, err);
  modport slave  (input start, A, p, output Inv, flag, busy, err);

endinterface

// File: rtl/modular_subtractor.sv
// Combinational (a - b) mod m for a, b already in [0, m-1].
// A borrow means the raw difference wrapped, so adding m restores the canonical residue.
module modular_subtractor #(
  parameter int W = 193
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic [W-1:0] diff
);

  logic [W:0] raw_s;

  // Subtract with an extra borrow bit, then fold negative results back by m.
  always_comb begin
    raw_s = {1'b0, a} - {1'b0, b};
    if (raw_s[W]) begin
      diff = raw_s[W-1:0] + m;
    end else begin
      diff = raw_s[W-1:0];
    end
  end

endmodule

// File: rtl/modular_inverter.sv
// Binary extended-Euclid inverter: Inv = A^-1 mod p, one reduction step per clock.
// Keeps x1*A == u and x2*A == v (mod p) with x1, x2 held in [0, p-1].
module modular_inverter
  import ecc_pkg::*;
#(
  parameter int N = 192
) (
  input  logic                clk,
  input  logic                reset,
  modular_inverter_if.slave   bus
);

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  inv_state_e   state_r;
  logic [N-1:0] u_r;
  logic [N-1:0] v_r;
  logic [N:0]   x1_r;
  logic [N:0]   x2_r;
  logic         err_pend_r;

  logic [N:0]   p_ext_s;
  logic [N:0]   x1_sub_s;
  logic [N:0]   x2_sub_s;
  logic [N:0]   x_sel_s;
  logic         a_bad_s;

  // Halve modulo an odd m: odd values get m added first so the shift is exact.
  function automatic logic [N:0] halve_mod(input logic [N:0] x, input logic [N:0] m);
    logic [N:0] t;
    if (x[0]) begin
      t = x + m;
    end else begin
      t = x;
    end
    return t >> 1;
  endfunction

  assign p_ext_s = {1'b0, bus.p};

  modular_subtractor #(.W(N + 1)) u_sub_x1 (
    .a    (x1_r),
    .b    (x2_r),
    .m    (p_ext_s),
    .diff (x1_sub_s)
  );

  modular_subtractor #(.W(N + 1)) u_sub_x2 (
    .a    (x2_r),
    .b    (x1_r),
    .m    (p_ext_s),
    .diff (x2_sub_s)
  );

  // Operand validity and the coefficient that carries the inverse at completion.
  always_comb begin
    a_bad_s = (bus.A == {N{1'b0}}) || (bus.A >= bus.p);
    if (u_r == ONE_N) begin
      x_sel_s = x1_r;
    end else begin
      x_sel_s = x2_r;
    end
  end

  // Control FSM and datapath registers, including the registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      u_r        <= {N{1'b0}};
      v_r        <= {N{1'b0}};
      x1_r       <= {(N+1){1'b0}};
      x2_r       <= {(N+1){1'b0}};
      err_pend_r <= 1'b0;
      bus.Inv    <= {N{1'b0}};
      bus.flag   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          bus.flag <= 1'b0;
          if (bus.start) begin
            bus.busy <= 1'b1;
            bus.err  <= 1'b0;
            if (a_bad_s) begin
              err_pend_r <= 1'b1;
              state_r    <= DONE;
            end else begin
              err_pend_r <= 1'b0;
              u_r        <= bus.A;
              v_r        <= bus.p;
              x1_r       <= {{N{1'b0}}, 1'b1};
              x2_r       <= {(N+1){1'b0}};
              state_r    <= LOOP;
            end
          end else begin
            bus.busy <= 1'b0;
          end
        end
        LOOP: begin
          if ((u_r == ONE_N) || (v_r == ONE_N)) begin
            state_r <= DONE;
          end else if (!u_r[0]) begin
            u_r  <= u_r >> 1;
            x1_r <= halve_mod(x1_r, p_ext_s);
          end else if (!v_r[0]) begin
            v_r  <= v_r >> 1;
            x2_r <= halve_mod(x2_r, p_ext_s);
          end else if (u_r >= v_r) begin
            u_r  <= u_r - v_r;
            x1_r <= x1_sub_s;
          end else begin
            v_r  <= v_r - u_r;
            x2_r <= x2_sub_s;
          end
        end
        DONE: begin
          bus.flag <= 1'b1;
          state_r  <= IDLE;
          if (err_pend_r) begin
            bus.Inv <= {N{1'b0}};
            bus.err <= 1'b1;
          end else begin
            bus.Inv <= N'((x_sel_s >= p_ext_s) ? (x_sel_s - p_ext_s) : x_sel_s);
            bus.err <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          bus.flag <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modular_inverter.sv
// Directed bench for modular_inverter: P-192 vectors and an exhaustive p=23 sweep,
// plus hand-written reset, busy-start and back-to-back sequences.
module tb_modular_inverter;
  import ecc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  modular_inverter_if #(.N(192)) b192 ();
  modular_inverter_if #(.N(8))   b8 ();

  modular_inverter #(.N(192)) dut192 (.clk(clk), .reset(reset), .bus(b192.slave));
  modular_inverter #(.N(8))   dut8   (.clk(clk), .reset(reset), .bus(b8.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [191:0] a;
    logic [191:0] inv;
    logic         err;
    int           lat;
    bit           model;
  } vec192_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] inv;
    logic       err;
  } vec8_t;

  vec192_t t192[6];
  vec8_t   t8[25];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] mulmod192(input logic [191:0] a, input logic [191:0] b);
    logic [383:0] pr;
    pr = {192'd0, a} * {192'd0, b};
    pr = pr % {192'd0, P192};
    return pr[191:0];
  endfunction

  // Start one P-192 inversion; optionally pulse start while busy.
  task automatic run192(input logic [191:0] a, input bit pulse, output logic [191:0] inv,
                        output logic e, output int cyc);
    @(negedge clk);
    b192.start = 1'b1;
    b192.A = a;
    @(posedge clk);
    #1;
    b192.start = 1'b0;
    chk("busy_after_start192", 192'(b192.busy), 192'd1);
    cyc = 0;
    while (!b192.flag && cyc < 772) begin
      if (pulse && cyc >= 1 && cyc <= 4) begin
        b192.start = cyc[0];
        b192.A = 192'd5;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    b192.start = 1'b0;
    chk("flag_seen192", 192'(b192.flag), 192'd1);
    chk("busy_with_flag192", 192'(b192.busy), 192'd1);
    inv = b192.Inv;
    e = b192.err;
    @(posedge clk);
    #1;
    chk("flag_drop192", 192'(b192.flag), 192'd0);
    chk("busy_drop192", 192'(b192.busy), 192'd0);
  endtask

  task automatic run8(input logic [7:0] a, output logic [7:0] inv, output logic e, output int cyc);
    @(negedge clk);
    b8.start = 1'b1;
    b8.A = a;
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    cyc = 0;
    while (!b8.flag && cyc < 36) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("flag_seen8", 192'(b8.flag), 192'd1);
    inv = b8.Inv;
    e = b8.err;
    @(posedge clk);
    #1;
    chk("flag_drop8", 192'(b8.flag), 192'd0);
  endtask

  initial begin
    logic [191:0] inv;
    logic [191:0] third;
    logic [7:0]   inv8;
    logic [7:0]   inv_tab [0:22];
    logic         e;
    int           cyc;
    int           lat_ref;

    b192.start = 1'b0;
    b192.A = 192'd0;
    b192.p = P192;
    b8.start = 1'b0;
    b8.A = 8'd0;
    b8.p = 8'd23;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_inv", b192.Inv, 192'd0);
    chk("rst_flag", 192'(b192.flag), 192'd0);
    chk("rst_busy", 192'(b192.busy), 192'd0);
    chk("rst_err", 192'(b192.err), 192'd0);
    chk("rst_flag8", 192'(b8.flag), 192'd0);
    @(negedge clk);
    reset = 1'b1;

    t192[0] = '{192'd1, 192'd1, 1'b0, 2, 1'b0};
    t192[1] = '{192'd0, 192'd0, 1'b1, 1, 1'b0};
    t192[2] = '{P192, 192'd0, 1'b1, 1, 1'b0};
    t192[3] = '{192'd2, 192'h7fffffffffffffffffffffffffffffff8000000000000000, 1'b0, 0, 1'b0};
    t192[4] = '{P192 - 192'd1, P192 - 192'd1, 1'b0, 0, 1'b0};
    t192[5] = '{192'hf3eaf3b95d6d94260bb91af829600303535b2b331893bd3d, 192'd0, 1'b0, 0, 1'b1};

    for (int i = 0; i < 6; i++) begin
      run192(t192[i].a, 1'b0, inv, e, cyc);
      if (t192[i].model) begin
        chk("a_times_inv", mulmod192(t192[i].a, inv), 192'd1);
      end else begin
        chk("inv192", inv, t192[i].inv);
      end
      chk("err192", 192'(e), 192'(t192[i].err));
      chk("err_hold192", 192'(b192.err), 192'(t192[i].err));
      if (t192[i].lat != 0) begin
        chk("latency192", 192'(cyc), 192'(t192[i].lat));
      end else begin
        chk("latency_bound192", 192'(cyc <= 772), 192'd1);
      end
    end

    third = (P192 + 192'd1) / 192'd3;
    run192(192'd3, 1'b0, inv, e, lat_ref);
    chk("inv_of_3", inv, third);
    b192.A = 192'd0;
    run192(192'd3, 1'b0, inv, e, cyc);
    run192(192'd3, 1'b1, inv, e, cyc);
    chk("inv_of_3_busy_starts", inv, third);
    chk("latency_busy_starts", 192'(cyc), 192'(lat_ref));

    // Reset pulse in the middle of a long inversion.
    @(negedge clk);
    b192.start = 1'b1;
    b192.A = 192'hf3eaf3b95d6d94260bb91af829600303535b2b331893bd3d;
    @(posedge clk);
    #1;
    b192.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_mid_loop", 192'(b192.busy), 192'd1);
    reset = 1'b0;
    #1;
    chk("midrst_inv", b192.Inv, 192'd0);
    chk("midrst_flag", 192'(b192.flag), 192'd0);
    chk("midrst_busy", 192'(b192.busy), 192'd0);
    chk("midrst_err", 192'(b192.err), 192'd0);
    @(posedge clk);
    #1;
    chk("midrst_busy_held", 192'(b192.busy), 192'd0);
    @(negedge clk);
    reset = 1'b1;
    run192(192'd3, 1'b0, inv, e, cyc);
    chk("inv_of_3_after_rst", inv, third);

    inv_tab = '{8'd0, 8'd1, 8'd12, 8'd8, 8'd6, 8'd14, 8'd4, 8'd10, 8'd3, 8'd18, 8'd7, 8'd21,
                8'd2, 8'd16, 8'd5, 8'd20, 8'd13, 8'd19, 8'd9, 8'd17, 8'd15, 8'd11, 8'd22};
    for (int i = 0; i < 23; i++) begin
      t8[i] = '{8'(i), inv_tab[i], (i == 0)};
    end
    t8[23] = '{8'd23, 8'd0, 1'b1};
    t8[24] = '{8'd200, 8'd0, 1'b1};

    for (int i = 0; i < 25; i++) begin
      run8(t8[i].a, inv8, e, cyc);
      chk($sformatf("inv8_a%0d", t8[i].a), 192'(inv8), 192'(t8[i].inv));
      chk($sformatf("err8_a%0d", t8[i].a), 192'(e), 192'(t8[i].err));
    end

    // Back-to-back: start again in the flag cycle.
    @(negedge clk);
    b8.start = 1'b1;
    b8.A = 8'd5;
    @(posedge clk);
    #1;
    cyc = 0;
    b8.A = 8'd7;
    while (!b8.flag && cyc < 36) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("b2b_first_flag", 192'(b8.flag), 192'd1);
    chk("b2b_first_inv", 192'(b8.Inv), 192'd14);
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    chk("b2b_accepted_busy", 192'(b8.busy), 192'd1);
    chk("b2b_flag_low", 192'(b8.flag), 192'd0);
    cyc = 0;
    while (!b8.flag && cyc < 36) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("b2b_second_flag", 192'(b8.flag), 192'd1);
    chk("b2b_second_inv", 192'(b8.Inv), 192'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
